// File: rtl/axis_mem_write_arbiter.sv
// axis_mem_write_arbiter: round-robin, packet-locked arbiter of two AXIS producers
// onto one registered AXIS write port, with per-port packet counters and an over-length flag.
module axis_mem_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                    s00_axis_tvalid,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tvalid,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tvalid,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready,
    output logic [1:0]              grant,
    output logic [CNT_WIDTH-1:0]    pkt_cnt0,
    output logic [CNT_WIDTH-1:0]    pkt_cnt1,
    output logic                    err_overlen
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]         strb_q, strb_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [CNT_WIDTH-1:0]  pkt0_q, pkt0_d, pkt1_q, pkt1_d;
    logic                  err_q, err_d;
    logic                  slot_free, sel, acc, sel_last, limit, last_out;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [SW-1:0]         sel_strb;

    // The output slice can take a new beat when empty or being drained this cycle.
    assign slot_free       = ~valid_q | m00_axis_tready;
    assign s00_axis_tready = (state_q == GNT0) & slot_free;
    assign s01_axis_tready = (state_q == GNT1) & slot_free;
    assign sel             = state_q == GNT1;
    assign acc             = (s00_axis_tvalid & s00_axis_tready) | (s01_axis_tvalid & s01_axis_tready);
    assign sel_data        = sel ? s01_axis_tdata : s00_axis_tdata;
    assign sel_strb        = sel ? s01_axis_tstrb : s00_axis_tstrb;
    assign sel_last        = sel ? s01_axis_tlast : s00_axis_tlast;
    assign limit           = beat_cnt_q == BW'(MAX_BEATS - 1);
    assign last_out        = sel_last | limit;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        data_d       = data_q;
        strb_d       = strb_q;
        valid_d      = valid_q;
        last_d       = last_q;
        pkt0_d       = pkt0_q;
        pkt1_d       = pkt1_q;
        err_d        = err_q;
        // On a tie the port that did not own the previous packet wins.
        if (state_q == IDLE && (s00_axis_tvalid | s01_axis_tvalid))
            state_d = (s00_axis_tvalid & (~s01_axis_tvalid | last_grant_q)) ? GNT0 : GNT1;
        if (acc) begin
            data_d     = sel_data;
            strb_d     = sel_strb;
            last_d     = last_out;
            valid_d    = 1'b1;
            beat_cnt_d = last_out ? '0 : beat_cnt_q + BW'(1);
            if (last_out) begin
                state_d      = IDLE;
                last_grant_d = sel;
                pkt0_d       = sel ? pkt0_q : pkt0_q + CNT_WIDTH'(1);
                pkt1_d       = sel ? pkt1_q + CNT_WIDTH'(1) : pkt1_q;
                err_d        = err_q | (limit & ~sel_last);
            end
        end else if (valid_q & m00_axis_tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            data_q       <= '0;
            strb_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            pkt0_q       <= '0;
            pkt1_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            data_q       <= data_d;
            strb_q       <= strb_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            pkt0_q       <= pkt0_d;
            pkt1_q       <= pkt1_d;
            err_q        <= err_d;
        end
    end

    assign m00_axis_tdata  = data_q;
    assign m00_axis_tstrb  = strb_q;
    assign m00_axis_tvalid = valid_q;
    assign m00_axis_tlast  = last_q;
    assign grant           = {state_q == GNT1, state_q == GNT0};
    assign pkt_cnt0        = pkt0_q;
    assign pkt_cnt1        = pkt1_q;
    assign err_overlen     = err_q;
endmodule

// File: tb/tb_axis_mem_write_arbiter.sv
// tb_axis_mem_write_arbiter: directed bench for the two-port AXIS write arbiter
// (MAX_BEATS=4 and CNT_WIDTH=4 so the length limit and counter wrap are reachable).
module tb_axis_mem_write_arbiter;
    typedef logic [36:0] beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] s0_data = '0, s1_data = '0, m_data;
    logic [3:0]  s0_strb = '0, s1_strb = '0, m_strb;
    logic        s0_valid = 1'b0, s1_valid = 1'b0, s0_last = 1'b0, s1_last = 1'b0;
    logic        s0_ready, s1_ready, m_valid, m_last;
    logic        m_ready = 1'b1;
    logic [1:0]  grant;
    logic [3:0]  pkt_cnt0, pkt_cnt1;
    logic        err_overlen;
    logic        h0, h1;
    beat_t       q0[$], q1[$], outq[$], expq[$];
    logic [1:0]  exp_gnt[6];
    int          n_cmp = 0, n_err = 0;

    axis_mem_write_arbiter #(.DATA_WIDTH(32), .MAX_BEATS(4), .CNT_WIDTH(4)) dut (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s00_axis_tdata(s0_data), .s00_axis_tstrb(s0_strb), .s00_axis_tvalid(s0_valid),
        .s00_axis_tlast(s0_last), .s00_axis_tready(s0_ready),
        .s01_axis_tdata(s1_data), .s01_axis_tstrb(s1_strb), .s01_axis_tvalid(s1_valid),
        .s01_axis_tlast(s1_last), .s01_axis_tready(s1_ready),
        .m00_axis_tdata(m_data), .m00_axis_tstrb(m_strb), .m00_axis_tvalid(m_valid),
        .m00_axis_tlast(m_last), .m00_axis_tready(m_ready),
        .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .err_overlen(err_overlen)
    );

    always #5 clk = ~clk;

    function automatic beat_t bt(logic l, logic [3:0] s, logic [31:0] d);
        return {l, s, d};
    endfunction

    function automatic logic idle();
        return q0.size() == 0 && q1.size() == 0 && !m_valid && grant == 2'b00;
    endfunction

    task automatic present();
        s0_valid = q0.size() != 0;
        {s0_last, s0_strb, s0_data} = (q0.size() != 0) ? q0[0] : '0;
        s1_valid = q1.size() != 0;
        {s1_last, s1_strb, s1_data} = (q1.size() != 0) ? q1[0] : '0;
    endtask

    // Handshakes are judged on the stable mid-cycle values, then sources advance after the edge.
    task automatic cyc();
        @(negedge clk);
        if (m_valid && m_ready) outq.push_back({m_last, m_strb, m_data});
        h0 = s0_valid & s0_ready;
        h1 = s1_valid & s1_ready;
        @(posedge clk);
        #1;
        if (h0 && q0.size() != 0) void'(q0.pop_front());
        if (h1 && q1.size() != 0) void'(q1.pop_front());
        present();
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(string tag);
        chk({tag, "_count"}, 64'(outq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            if (i < outq.size()) chk($sformatf("%s_beat%0d", tag, i), outq[i], expq[i]);
        outq.delete();
        expq.delete();
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 100 && !idle(); i++) cyc();
        chk({tag, "_drain"}, idle(), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        present();
        repeat (2) cyc();
        outq.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_mlast", m_last, 0);
        chk("rst_s0ready", s0_ready, 0);
        chk("rst_cnts", {pkt_cnt0, pkt_cnt1, err_overlen}, 0);
        @(posedge clk);
        #1;
        do_reset();
        // T1: single 3-beat packet on port 0
        q0 = '{bt(0, 4'hF, 32'hA000_0001), bt(0, 4'h3, 32'hA000_0002), bt(1, 4'hC, 32'hA000_0003)};
        present();
        cyc();
        chk("t1_grant", grant, 2'b01);
        chk("t1_mvalid0", m_valid, 0);
        cyc();
        chk("t1_a1", {m_valid, m_last, m_strb, m_data}, {2'b10, 4'hF, 32'hA000_0001});
        cyc();
        chk("t1_a2", {m_valid, m_last, m_strb, m_data}, {2'b10, 4'h3, 32'hA000_0002});
        cyc();
        chk("t1_a3", {m_valid, m_last, m_strb, m_data}, {2'b11, 4'hC, 32'hA000_0003});
        chk("t1_grant_idle", grant, 2'b00);
        chk("t1_pkt_cnt0", pkt_cnt0, 1);
        cyc();
        chk("t1_mvalid_clr", m_valid, 0);
        expq = '{bt(0, 4'hF, 32'hA000_0001), bt(0, 4'h3, 32'hA000_0002), bt(1, 4'hC, 32'hA000_0003)};
        chk_out("t1_out");
        // T2: simultaneous requests right after reset, then a repeat to show alternation
        do_reset();
        q0 = '{bt(0, 4'hF, 32'hB000_0001), bt(1, 4'hF, 32'hB000_0002)};
        q1 = '{bt(0, 4'hF, 32'hC000_0001), bt(1, 4'hF, 32'hC000_0002)};
        present();
        exp_gnt = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("t2_grant%0d", i), grant, exp_gnt[i]);
        end
        q0 = '{bt(0, 4'hF, 32'hD000_0001), bt(1, 4'hF, 32'hD000_0002)};
        q1 = '{bt(0, 4'hF, 32'hE000_0001), bt(1, 4'hF, 32'hE000_0002)};
        present();
        cyc();
        chk("t2_alt_grant", grant, 2'b01);
        drain("t2");
        expq = '{bt(0, 4'hF, 32'hB000_0001), bt(1, 4'hF, 32'hB000_0002),
                 bt(0, 4'hF, 32'hC000_0001), bt(1, 4'hF, 32'hC000_0002),
                 bt(0, 4'hF, 32'hD000_0001), bt(1, 4'hF, 32'hD000_0002),
                 bt(0, 4'hF, 32'hE000_0001), bt(1, 4'hF, 32'hE000_0002)};
        chk_out("t2_out");
        // T3: backpressure for 5 cycles inside a 4-beat port 1 packet
        q1 = '{bt(0, 4'h1, 32'hF000_0001), bt(0, 4'h2, 32'hF000_0002),
               bt(0, 4'h4, 32'hF000_0003), bt(1, 4'h8, 32'hF000_0004)};
        present();
        cyc();
        cyc();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("t3_hold%0d", i), {m_valid, m_last, m_strb, m_data}, {2'b10, 4'h1, 32'hF000_0001});
            chk($sformatf("t3_s1ready%0d", i), s1_ready, 0);
        end
        m_ready = 1'b1;
        drain("t3");
        expq = '{bt(0, 4'h1, 32'hF000_0001), bt(0, 4'h2, 32'hF000_0002),
                 bt(0, 4'h4, 32'hF000_0003), bt(1, 4'h8, 32'hF000_0004)};
        chk_out("t3_out");
        chk("t3_err_exact_len", err_overlen, 0);
        chk("t3_pkt_cnt1", pkt_cnt1, 3);
        // T4: 6-beat packet against a 4-beat limit
        do_reset();
        chk("t4_err_pre", err_overlen, 0);
        for (int i = 1; i <= 6; i++) q0.push_back(bt(i == 6, 4'hF, 32'h4000_0000 + 32'(i)));
        present();
        drain("t4");
        expq = '{bt(0, 4'hF, 32'h4000_0001), bt(0, 4'hF, 32'h4000_0002), bt(0, 4'hF, 32'h4000_0003),
                 bt(1, 4'hF, 32'h4000_0004), bt(0, 4'hF, 32'h4000_0005), bt(1, 4'hF, 32'h4000_0006)};
        chk_out("t4_out");
        chk("t4_err", err_overlen, 1);
        chk("t4_pkt_cnt0", pkt_cnt0, 2);
        // T5: asynchronous reset in the middle of a 5-beat packet
        for (int i = 1; i <= 5; i++) q0.push_back(bt(i == 5, 4'hF, 32'h5000_0000 + 32'(i)));
        present();
        cyc();
        cyc();
        cyc();
        chk("t5_beat2", m_data, 32'h5000_0002);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_grant", grant, 0);
        chk("t5_mout", {m_valid, m_last, m_strb, m_data}, 0);
        chk("t5_s0ready", s0_ready, 0);
        chk("t5_status", {pkt_cnt0, pkt_cnt1, err_overlen}, 0);
        q0.delete();
        present();
        repeat (2) cyc();
        outq.delete();
        rst_n = 1'b1;
        q0 = '{bt(0, 4'h5, 32'h5100_0001), bt(1, 4'hA, 32'h5100_0002)};
        present();
        drain("t5");
        expq = '{bt(0, 4'h5, 32'h5100_0001), bt(1, 4'hA, 32'h5100_0002)};
        chk_out("t5_out");
        chk("t5_pkt_cnt0", pkt_cnt0, 1);
        // T6: 17 single-beat packets wrap the 4-bit port 1 counter
        for (int i = 0; i < 17; i++) begin
            q1.push_back(bt(1, 4'hF, 32'h6000_0000 + 32'(i)));
            expq.push_back(bt(1, 4'hF, 32'h6000_0000 + 32'(i)));
        end
        present();
        drain("t6");
        chk_out("t6_out");
        chk("t6_pkt_cnt1_wrap", pkt_cnt1, 1);
        chk("t6_err", err_overlen, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
